// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between NUM_REQ requesters.
// Optional per-requester grant counters are enabled with `define ALU_ARB_PERF_EN.
module alu_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
  input  logic [NUM_REQ*4-1:0]      req_op_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  input  logic [NUM_REQ-1:0]        rsp_ready_i,
  output logic [DATA_W-1:0]         rsp_result_o,
  output logic                      rsp_zero_o,
  output logic [DATA_W-1:0]         alu_a_o,
  output logic [DATA_W-1:0]         alu_b_o,
  output logic [3:0]                alu_op_o,
  input  logic [DATA_W-1:0]         alu_result_i,
  input  logic                      alu_zero_i
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [NUM_REQ*16-1:0]     perf_grant_cnt_o
`endif
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     last_grant_q, last_grant_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;

  logic              pick_found;
  logic [GW-1:0]     pick_idx;

  // Scan starts one past the previous winner so a continuously requesting
  // master cannot starve the others.
  always_comb begin
    logic [GW-1:0] cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(last_grant_q) + k) % NUM_REQ);
      if (!pick_found && req_valid_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    result_d     = result_q;
    zero_d       = zero_q;
    req_ready_o  = '0;
    rsp_valid_o  = '0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          req_ready_o  = NUM_REQ'(1) << pick_idx;
          a_d          = req_a_i[pick_idx*DATA_W +: DATA_W];
          b_d          = req_b_i[pick_idx*DATA_W +: DATA_W];
          op_d         = req_op_i[pick_idx*4 +: 4];
          grant_d      = pick_idx;
          last_grant_d = pick_idx;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_result_i;
        zero_d   = alu_zero_i;
        state_d  = RESP;
      end
      RESP: begin
        rsp_valid_o = NUM_REQ'(1) << grant_q;
        // Only the granted requester may retire the response.
        if (rsp_ready_i[grant_q]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
    end
  end

  assign alu_a_o      = a_q;
  assign alu_b_o      = b_q;
  assign alu_op_o     = op_q;
  assign rsp_result_o = result_q;
  assign rsp_zero_o   = zero_q;

`ifdef ALU_ARB_PERF_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf
    logic [15:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else if ((state_q == IDLE) && pick_found && (pick_idx == GW'(gi))) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end

    assign perf_grant_cnt_o[gi*16 +: 16] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural RV32I ALU attached.
// Op encoding used by the ALU model: 0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [7:0]  req_op = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = '0;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;
  logic        alu_zero;
`ifdef ALU_ARB_PERF_EN
  logic [31:0] perf_cnt;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NUM_REQ(2), .DATA_W(32)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_op_i     (req_op),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_result_o (rsp_result),
    .rsp_zero_o   (rsp_zero),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_op_o     (alu_op),
    .alu_result_i (alu_result),
    .alu_zero_i   (alu_zero)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_grant_cnt_o (perf_cnt)
`endif
  );

  always_comb begin
    alu_result = '0;
    case (alu_op)
      4'd0: alu_result = alu_a + alu_b;
      4'd1: alu_result = alu_a - alu_b;
      4'd2: alu_result = alu_a << alu_b[4:0];
      4'd3: alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      4'd4: alu_result = {31'b0, alu_a < alu_b};
      4'd5: alu_result = alu_a ^ alu_b;
      4'd6: alu_result = alu_a >> alu_b[4:0];
      4'd7: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      4'd8: alu_result = alu_a | alu_b;
      4'd9: alu_result = alu_a & alu_b;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
    checks++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 4'd0) begin fails++; $display("FAIL reset_alu_regs: got a=%h b=%h op=%h expected 0/0/0", alu_a, alu_b, alu_op); end
    checks++; if (rsp_result !== 32'd0 || rsp_zero !== 1'b0) begin fails++; $display("FAIL reset_result: got %h/%b expected 0/0", rsp_result, rsp_zero); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 2'b01; req_a[31:0] = 32'd5; req_b[31:0] = 32'd7; req_op[3:0] = 4'd0;
    #1;
    checks++; if (req_ready !== 2'b01) begin fails++; $display("FAIL single_ready: got %b expected 01", req_ready); end
    tick();
    req_valid = 2'b00;
    #1;
    checks++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL single_exec_valid: got %b expected 00", rsp_valid); end
    checks++; if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_op !== 4'd0) begin fails++; $display("FAIL single_alu_in: got a=%0d b=%0d op=%0d expected 5/7/0", alu_a, alu_b, alu_op); end
    tick();
    checks++; if (rsp_valid !== 2'b01) begin fails++; $display("FAIL single_rsp_valid: got %b expected 01", rsp_valid); end
    checks++; if (rsp_result !== 32'd12 || rsp_zero !== 1'b0) begin fails++; $display("FAIL single_result: got %0d/%b expected 12/0", rsp_result, rsp_zero); end
    $display("txn single: req0 ADD 5+7 -> %0d zero=%b", rsp_result, rsp_zero);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    #1;
    checks++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL single_rsp_drop: got %b expected 00", rsp_valid); end
    checks++; if (alu_a !== 32'd5 || alu_b !== 32'd7) begin fails++; $display("FAIL single_alu_hold: got a=%0d b=%0d expected 5/7", alu_a, alu_b); end
  endtask

  task automatic test_back_to_back();
    int n;
    int last_acc;
    logic [1:0] exp_oh;
    do_reset();
    req_a = {32'd1, 32'd3}; req_b = {32'd2, 32'd3}; req_op = {4'd4, 4'd1};
    req_valid = 2'b11; rsp_ready = 2'b11;
    n = 0; last_acc = -1;
    #1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (rsp_valid !== 2'b00) begin
        exp_oh = ((n - 1) % 2 == 0) ? 2'b01 : 2'b10;
        checks++; if (rsp_valid !== exp_oh) begin fails++; $display("FAIL b2b_rsp_valid: got %b expected %b at cycle %0d", rsp_valid, exp_oh, cyc); end
        if (exp_oh == 2'b01) begin
          checks++; if (rsp_result !== 32'd0 || rsp_zero !== 1'b1) begin fails++; $display("FAIL b2b_sub_result: got %0d/%b expected 0/1", rsp_result, rsp_zero); end
        end else begin
          checks++; if (rsp_result !== 32'd1 || rsp_zero !== 1'b0) begin fails++; $display("FAIL b2b_sltu_result: got %0d/%b expected 1/0", rsp_result, rsp_zero); end
        end
        $display("txn b2b: response to %b result=%0d zero=%b", rsp_valid, rsp_result, rsp_zero);
      end
      if (req_ready !== 2'b00) begin
        exp_oh = (n % 2 == 0) ? 2'b01 : 2'b10;
        checks++; if (req_ready !== exp_oh) begin fails++; $display("FAIL b2b_grant_order: got %b expected %b for grant %0d", req_ready, exp_oh, n); end
        if (last_acc >= 0) begin
          checks++; if (cyc - last_acc != 3) begin fails++; $display("FAIL b2b_spacing: got %0d expected 3 cycles", cyc - last_acc); end
        end
        last_acc = cyc;
        n++;
      end
      tick();
    end
    checks++; if (n != 4) begin fails++; $display("FAIL b2b_accept_count: got %0d expected 4", n); end
    req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 2'b10; req_a[63:32] = 32'h8000_0000; req_b[63:32] = 32'd4; req_op[7:4] = 4'd7;
    #1;
    checks++; if (req_ready !== 2'b10) begin fails++; $display("FAIL bp_ready_req1: got %b expected 10", req_ready); end
    tick();
    req_valid = 2'b01; req_a[31:0] = 32'd2; req_b[31:0] = 32'd3; req_op[3:0] = 4'd0;
    #1;
    checks++; if (req_ready !== 2'b00) begin fails++; $display("FAIL bp_ready_exec: got %b expected 00", req_ready); end
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 2'b10) begin fails++; $display("FAIL bp_rsp_held: got %b expected 10 (cycle %0d)", rsp_valid, i); end
      checks++; if (rsp_result !== 32'hF800_0000) begin fails++; $display("FAIL bp_result_stable: got %h expected f8000000", rsp_result); end
      checks++; if (req_ready !== 2'b00) begin fails++; $display("FAIL bp_req0_blocked: got %b expected 00", req_ready); end
      tick();
    end
    rsp_ready = 2'b10;
    #1;
    checks++; if (rsp_valid !== 2'b10 || req_ready !== 2'b00) begin fails++; $display("FAIL bp_take_cycle: got rsp=%b ready=%b expected 10/00", rsp_valid, req_ready); end
    $display("txn backpressure: req1 SRA -> %h", rsp_result);
    tick();
    rsp_ready = 2'b00;
    #1;
    checks++; if (req_ready !== 2'b01) begin fails++; $display("FAIL bp_req0_accept: got %b expected 01", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
    checks++; if (rsp_valid !== 2'b01 || rsp_result !== 32'd5) begin fails++; $display("FAIL bp_req0_result: got %b/%0d expected 01/5", rsp_valid, rsp_result); end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_wrong_ack();
    do_reset();
    req_valid = 2'b01; req_a[31:0] = 32'd9; req_b[31:0] = 32'd6; req_op[3:0] = 4'd8;
    tick();
    req_valid = 2'b00;
    tick();
    rsp_ready = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (rsp_valid !== 2'b01) begin fails++; $display("FAIL wrong_ack_held: got %b expected 01 (cycle %0d)", rsp_valid, i); end
      tick();
    end
    checks++; if (rsp_result !== 32'd15) begin fails++; $display("FAIL wrong_ack_result: got %0d expected 15", rsp_result); end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    #1;
    checks++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL wrong_ack_release: got %b expected 00", rsp_valid); end
    $display("txn wrong_ack: req0 OR 9|6 -> %0d", rsp_result);
  endtask

  task automatic test_reset_mid_exec();
    do_reset();
    req_valid = 2'b01; req_a[31:0] = 32'h0000_0F0F; req_b[31:0] = 32'h0000_00FF; req_op[3:0] = 4'd5;
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (alu_a !== 32'd0 || alu_op !== 4'd0) begin fails++; $display("FAIL midrst_alu_cleared: got a=%h op=%h expected 0/0", alu_a, alu_op); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL midrst_no_rsp: got %b expected 00 (cycle %0d)", rsp_valid, i); end
      tick();
    end
    rst_n = 1'b1;
    #1;
    checks++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL midrst_no_rsp_after: got %b expected 00", rsp_valid); end
    checks++; if (req_ready !== 2'b01) begin fails++; $display("FAIL midrst_ready_again: got %b expected 01", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
    checks++; if (rsp_valid !== 2'b01 || rsp_result !== 32'h0000_0FF0) begin fails++; $display("FAIL midrst_xor_result: got %b/%h expected 01/00000ff0", rsp_valid, rsp_result); end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_undefined_op();
    do_reset();
    req_valid = 2'b10; req_a[63:32] = 32'd1; req_b[63:32] = 32'd1; req_op[7:4] = 4'd12;
    tick();
    req_valid = 2'b00;
    #1;
    checks++; if (alu_op !== 4'd12) begin fails++; $display("FAIL undef_op_pass: got %0d expected 12", alu_op); end
    tick();
    checks++; if (rsp_valid !== 2'b10 || rsp_result !== 32'd0 || rsp_zero !== 1'b1) begin fails++; $display("FAIL undef_op_result: got %b/%0d/%b expected 10/0/1", rsp_valid, rsp_result, rsp_zero); end
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
  endtask

`ifdef ALU_ARB_PERF_EN
  task automatic run_op(input logic [1:0] who);
    req_valid = who;
    tick();
    req_valid = 2'b00;
    tick();
    rsp_ready = 2'b11;
    tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_perf();
    do_reset();
    req_a = '0; req_b = '0; req_op = '0;
    run_op(2'b01); run_op(2'b01); run_op(2'b10); run_op(2'b01); run_op(2'b10);
    checks++; if (perf_cnt !== {16'd2, 16'd3}) begin fails++; $display("FAIL perf_counts: got %h expected 00020003", perf_cnt); end
    force dut.g_perf[0].cnt_q = 16'hFFFF;
    #1;
    release dut.g_perf[0].cnt_q;
    run_op(2'b01);
    checks++; if (perf_cnt[15:0] !== 16'h0000) begin fails++; $display("FAIL perf_wrap: got %h expected 0000", perf_cnt[15:0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_wrong_ack();
    test_reset_mid_exec();
    test_undefined_op();
`ifdef ALU_ARB_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single combinational RV32I ALU between NUM_REQ requesters, for example the execute stage and the branch/address-generation unit. Each requester uses a valid/ready request channel and a valid/ready response channel. The block arbitrates round-robin, registers operands into the ALU, captures result and zero flag, and returns them to the granted requester. One operation is in flight at a time.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
DATA_W, 32, operand/result width; must equal the ALU width

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
req_valid_i  input  NUM_REQ  per-requester request valid
req_ready_o  output  NUM_REQ  per-requester request accept (one-hot or zero)
req_a_i  input  NUM_REQ*DATA_W  operand A; requester k at bits [k*DATA_W +: DATA_W]
req_b_i  input  NUM_REQ*DATA_W  operand B, same packing
req_op_i  input  NUM_REQ*4  ALU op code, 4 bits per requester
rsp_valid_o  output  NUM_REQ  response valid, one-hot or zero
rsp_ready_i  input  NUM_REQ  response accept
rsp_result_o  output  DATA_W  captured result, shared by all requesters
rsp_zero_o  output  1  captured zero flag
alu_a_o  output  DATA_W  to ALU a_i
alu_b_o  output  DATA_W  to ALU b_i
alu_op_o  output  4  to ALU alu_op_i
alu_result_i  input  DATA_W  from ALU result_o
alu_zero_i  input  1  from ALU zero_o

Behaviour:
- Reset (rst_ni low, asynchronous):
  - state=IDLE.
  - Operand, op, result and zero registers cleared to 0.
  - grant index = 0; last_grant = NUM_REQ-1, so requester 0 has first priority.
  - All req_ready_o and rsp_valid_o are 0.
  - Deassertion is synchronous to clk_i by the integrating logic.
- FSM states IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid_i is set, choose the first set requester scanning from (last_grant+1) mod NUM_REQ upward with wrap-around.
  - req_ready_o[g]=1 combinationally in that cycle.
  - On the clock edge: latch a/b/op of g; grant=g; last_grant=g; go to EXEC.
  - No valid: stay in IDLE, ready=0.
- EXEC:
  - alu_a_o/alu_b_o/alu_op_o driven from the latched registers.
  - On the edge: capture alu_result_i and alu_zero_i; go to RESP.
- RESP:
  - rsp_valid_o[grant]=1; rsp_result_o/rsp_zero_o hold the captured values.
  - When rsp_ready_i[grant]=1: go to IDLE.
  - rsp_ready_i bits of non-granted requesters are ignored.
  - Response is held indefinitely under backpressure.
- req_ready_o is 0 outside IDLE, so requests arriving during EXEC/RESP wait.
- Requesters hold valid and payload stable until ready. Dropping valid before ready is permitted; no request is then recorded.
- Latency:
  - accept at edge N;
  - rsp_valid_o high from cycle N+2;
  - minimum 3 cycles per operation with zero-wait response.
- Alu_*_o outside EXEC keep the last latched values (held registers, no glitching).
- Op codes are passed unmodified. Undefined codes 10..15 yield whatever the ALU returns (result 0, zero 1).
- Simultaneous valids: fairness is guaranteed. Two continuously requesting masters alternate grants 0,1,0,1.
- Reset mid-EXEC/RESP: operation discarded, no response issued, outputs as at reset.

Optional Feature:
ALU_ARB_PERF_EN:
- When defined, adds output perf_grant_cnt_o (NUM_REQ*16).
- One 16-bit counter per requester, incremented on each accepted request.
- Wraps 0xFFFF->0x0000; cleared by reset.
- When undefined, the port and counters are absent and the remaining behaviour is identical.

Test Plan:
- Reset, then single request: req0 ADD a=5 b=7 -> req_ready_o=01 in accept cycle; two cycles later rsp_valid_o=01, rsp_result_o=12, rsp_zero_o=0.
- Both valid every cycle: req0 SUB a=3 b=3, req1 SLTU a=1 b=2 with rsp_ready always 1 -> grant order 0,1,0,1; results 0/zero=1 and 1/zero=0; new accept every 3 cycles.
- Backpressure: req1 SRA a=0x80000000 b=4, rsp_ready_i low 5 cycles -> rsp_valid_o=10 held, result 0xF8000000 stable; req0 arriving meanwhile sees ready=0 until the response is taken.
- Reset asserted during EXEC with req0 XOR pending -> rsp_valid_o never asserts; after release req_ready_o=01 again when req0 is valid.
- Wrong requester acknowledging: grant=0 in RESP, rsp_ready_i=10 -> stays in RESP, rsp_valid_o=01.
- With ALU_ARB_PERF_EN: 3 grants to req0, 2 to req1 -> counters 3 and 2; a counter preloaded by forcing to 0xFFFF wraps to 0 on the next grant.
